// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit XNOR PRBS (taps 16,15,13,4), with windowed loss-of-lock detection.
// Define PRBS_CHK_ERR_INJECT_EN to add the err_inject port, which forces a single counted error.
module prbs16_checker #(
    parameter int LOCK_BITS = 32,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_cnt,
`ifdef PRBS_CHK_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    output logic             locked,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    // state     | meaning
    // ST_HUNT   | filling sr with 16 received bits
    // ST_VERIFY | counting consecutive correct predictions toward lock
    // ST_LOCKED | reference free-runs, errors counted per window
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_BITS);
    localparam logic [7:0]       WIN_C   = 8'(WINDOW);
    localparam logic [7:0]       LOSS_C  = 8'(LOSS_ERRS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [15:0]      sr_q, sr_d;
    logic [4:0]       fill_q, fill_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       win_bits_q, win_bits_d;
    logic [7:0]       win_errs_q, win_errs_d;
    logic             sync_loss_q, sync_loss_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             inj_armed_q, inj_armed_d;
    logic             inj_prev_q, inj_prev_d;

    logic       accept;
    logic       pred;
    logic       bit_err;
    logic [7:0] run_nxt;
    logic [7:0] win_bits_nxt;
    logic [7:0] win_errs_nxt;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        fill_d       = fill_q;
        run_d        = run_q;
        win_bits_d   = win_bits_q;
        win_errs_d   = win_errs_q;
        sync_loss_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        inj_armed_d  = inj_armed_q;
        inj_prev_d   = inj_prev_q;

        accept       = ena & bit_valid;
        pred         = ~(sr_q[15] ^ sr_q[14] ^ sr_q[12] ^ sr_q[3]);
        // An armed one-shot inverts only the comparison, never the reference.
        bit_err      = bit_in ^ pred ^ inj_armed_q;
        run_nxt      = run_q + 8'd1;
        win_bits_nxt = win_bits_q + 8'd1;
        win_errs_nxt = win_errs_q + {7'd0, bit_err};

        if (accept) begin
            case (state_q)
                ST_HUNT: begin
                    sr_d   = {sr_q[14:0], bit_in};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd15) begin
                        state_d = ST_VERIFY;
                        run_d   = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    sr_d = {sr_q[14:0], bit_in};
                    // The all-ones lockup pattern predicts itself and must never count.
                    if ((bit_in == pred) && (sr_q != 16'hFFFF)) begin
                        run_d = run_nxt;
                        if (run_nxt == LOCK_C) begin
                            state_d    = ST_LOCKED;
                            win_bits_d = 8'd0;
                            win_errs_d = 8'd0;
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    sr_d        = {sr_q[14:0], pred};
                    inj_armed_d = 1'b0;
                    bit_cnt_d   = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_ONE;
                    if (bit_err) begin
                        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_ONE;
                    end
                    win_bits_d = win_bits_nxt;
                    win_errs_d = win_errs_nxt;
                    if (win_errs_nxt >= LOSS_C) begin
                        state_d     = ST_HUNT;
                        fill_d      = 5'd0;
                        sync_loss_d = 1'b1;
                    end else if (win_bits_nxt == WIN_C) begin
                        win_bits_d = 8'd0;
                        win_errs_d = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = 5'd0;
                end
            endcase
        end

`ifdef PRBS_CHK_ERR_INJECT_EN
        if (ena) begin
            inj_prev_d = err_inject;
            if (err_inject && !inj_prev_q) begin
                inj_armed_d = 1'b1;
            end
        end
`else
        inj_armed_d = 1'b0;
        inj_prev_d  = 1'b0;
`endif

        if (ena && clear_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            sr_q        <= 16'h0000;
            fill_q      <= 5'd0;
            run_q       <= 8'd0;
            win_bits_q  <= 8'd0;
            win_errs_q  <= 8'd0;
            sync_loss_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            inj_armed_q <= 1'b0;
            inj_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            sync_loss_q <= sync_loss_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            inj_armed_q <= inj_armed_d;
            inj_prev_q  <= inj_prev_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign sync_loss = sync_loss_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: stream-level reference model compared every cycle, plus literal checkpoints.
// Exercises err_inject only when PRBS_CHK_ERR_INJECT_EN is defined.
module tb_prbs16_checker;
    localparam int LOCK_BITS = 32;
    localparam int WINDOW    = 64;
    localparam int LOSS_ERRS = 4;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam int P_SEARCH  = 0;
    localparam int P_CONFIRM = 1;
    localparam int P_TRACK   = 2;

    logic             clk = 1'b0;
    logic             rst_n, ena, bit_valid, bit_in, clear_cnt, tb_inj;
    logic             locked, sync_loss;
    logic [CNT_W-1:0] err_count, bit_count;

    prbs16_checker #(
        .LOCK_BITS(LOCK_BITS), .WINDOW(WINDOW), .LOSS_ERRS(LOSS_ERRS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear_cnt(clear_cnt),
`ifdef PRBS_CHK_ERR_INJECT_EN
        .err_inject(tb_inj),
`endif
        .locked(locked), .sync_loss(sync_loss), .err_count(err_count), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Generator feeding the DUT
    logic [15:0] gen;
    function automatic logic fb(input logic [15:0] s);
        return ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    endfunction
    function automatic logic gen_next();
        logic b;
        b   = fb(gen);
        gen = {gen[14:0], b};
        return b;
    endfunction

    // Stream-level model: last 16 received bits, a separate tracking generator once locked
    int          m_phase, m_fill, m_run, m_wpos, m_werr, m_err, m_bits;
    logic [15:0] m_hist, m_ref;
    bit          m_loss, m_armed, m_prev_inj;

    task automatic model_edge(input bit r, input bit en, input bit v, input bit b,
                              input bit clr, input bit inj);
        bit exp_b, e;
        m_loss = 1'b0;
        if (!r) begin
            m_phase = P_SEARCH; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
            m_err = 0; m_bits = 0; m_hist = '0; m_ref = '0; m_armed = 0; m_prev_inj = 0;
            return;
        end
        if (!en) return;
        if (v) begin
            if (m_phase == P_SEARCH) begin
                m_hist = {m_hist[14:0], b};
                m_fill++;
                if (m_fill == 16) begin m_phase = P_CONFIRM; m_run = 0; end
            end else if (m_phase == P_CONFIRM) begin
                if (b == fb(m_hist) && m_hist != 16'hFFFF) m_run++;
                else m_run = 0;
                m_hist = {m_hist[14:0], b};
                if (m_run == LOCK_BITS) begin
                    m_phase = P_TRACK; m_ref = m_hist; m_wpos = 0; m_werr = 0;
                end
            end else begin
                exp_b  = fb(m_ref);
                m_ref  = {m_ref[14:0], exp_b};
                e      = (b != exp_b) ^ m_armed;
                m_armed = 0;
                if (m_bits < CNT_MAX) m_bits++;
                if (e) begin
                    if (m_err < CNT_MAX) m_err++;
                    m_werr++;
                end
                m_wpos++;
                if (m_werr >= LOSS_ERRS) begin
                    m_phase = P_SEARCH; m_fill = 0; m_loss = 1'b1;
                end else if (m_wpos == WINDOW) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        if (inj && !m_prev_inj) m_armed = 1'b1;
        m_prev_inj = inj;
        if (clr) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic step(input bit r, input bit en, input bit v, input bit b,
                        input bit clr, input bit inj);
        rst_n = r; ena = en; bit_valid = v; bit_in = b; clear_cnt = clr; tb_inj = inj;
        @(posedge clk);
        model_edge(r, en, v, b, clr, inj);
        #1;
    endtask

    // Send n generator bits, inverting those at offsets f0/f1/f2; optional idle cycles between bits
    task automatic send(input int n, input int f0, input int f1, input int f2, input bit gap);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = gen_next();
            if (i == f0 || i == f1 || i == f2) b = ~b;
            step(1, 1, 1, b, 0, 0);
            if (gap && (i % 3 == 0)) step(1, 1, 0, 1'($urandom_range(1)), 0, 0);
        end
    endtask

    task automatic do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
    endtask

    // Every-cycle comparison against the model
    int lock_cycles = 0;
    int loss_pulses = 0;
    always @(negedge clk) begin
        check("cyc_locked", int'(locked), int'(m_phase == P_TRACK));
        check("cyc_sync_loss", int'(sync_loss), int'(m_loss));
        check("cyc_err_count", int'(err_count), m_err);
        check("cyc_bit_count", int'(bit_count), m_bits);
        if (locked) lock_cycles++;
        if (sync_loss) loss_pulses++;
    end

    initial begin
        logic b;
        int   snap;
        rst_n = 0; ena = 0; bit_valid = 0; bit_in = 0; clear_cnt = 0; tb_inj = 0;
        gen = 16'h0000;
        do_reset();
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err_count), 0);

        // Acquisition: 16 fill + 32 verified bits
        send(47, -1, -1, -1, 0);
        check("pre_lock_47", int'(locked), 0);
        send(1, -1, -1, -1, 0);
        check("lock_at_48", int'(locked), 1);
        check("lock_err0", int'(err_count), 0);
        send(100, -1, -1, -1, 1);
        check("bits_100", int'(bit_count), 100);
        check("err_clean", int'(err_count), 0);

        // Sub-threshold errors: locked bits 100..127 lie in window 64..127
        send(28, 1, 5, 10, 0);
        check("err_3", int'(err_count), 3);
        check("locked_3err", int'(locked), 1);
        send(64, 0, 30, 63, 0);
        send(64, 2, 40, 50, 0);
        check("err_9", int'(err_count), 9);
        check("bits_256", int'(bit_count), 256);
        check("locked_9err", int'(locked), 1);
        check("no_loss_yet", loss_pulses, 0);

        // ena low freezes everything while bit_valid toggles
        for (int i = 0; i < 10; i++) step(1, 0, 1'(i & 1), 1'($urandom_range(1)), 0, 0);
        check("ena0_err", int'(err_count), 9);
        check("ena0_bits", int'(bit_count), 256);
        check("ena0_locked", int'(locked), 1);

        // clear_cnt beats a simultaneous error increment
        b = gen_next();
        step(1, 1, 1, ~b, 1, 0);
        check("clr_err", int'(err_count), 0);
        check("clr_bits", int'(bit_count), 0);

        // Finish that window (locked bits 257..319) then lose lock in the next
        send(63, -1, -1, -1, 0);
        check("bits_63", int'(bit_count), 63);
        send(9, 0, 3, 6, 0);
        check("err_3b", int'(err_count), 3);
        b = gen_next();
        step(1, 1, 1, ~b, 0, 0);
        check("loss_pulse", int'(sync_loss), 1);
        check("loss_unlocked", int'(locked), 0);
        check("loss_err4", int'(err_count), 4);
        step(1, 1, 0, 0, 0, 0);
        check("loss_pulse_end", int'(sync_loss), 0);
        send(47, -1, -1, -1, 0);
        check("relock_47", int'(locked), 0);
        check("err_held", int'(err_count), 4);
        send(1, -1, -1, -1, 0);
        check("relock_48", int'(locked), 1);

        // Lockup pattern never locks
        do_reset();
        snap = lock_cycles;
        for (int i = 0; i < 200; i++) step(1, 1, 1, 1'b1, 0, 0);
        check("ones_no_lock", lock_cycles - snap, 0);

        // Alternating pattern never locks
        do_reset();
        snap = lock_cycles;
        for (int i = 0; i < 200; i++) step(1, 1, 1, 1'((i + 1) & 1), 0, 0);
        check("alt_no_lock", lock_cycles - snap, 0);

        // Reset while locked clears all outputs
        do_reset();
        gen = 16'h0000;
        send(48, -1, -1, -1, 0);
        send(10, 2, -1, -1, 0);
        check("pre_rst_err", int'(err_count), 1);
        check("pre_rst_bits", int'(bit_count), 10);
        step(0, 1, 1, 1, 0, 0);
        check("rst_mid_locked", int'(locked), 0);
        check("rst_mid_loss", int'(sync_loss), 0);
        check("rst_mid_err", int'(err_count), 0);
        check("rst_mid_bits", int'(bit_count), 0);

`ifdef PRBS_CHK_ERR_INJECT_EN
        do_reset();
        gen = 16'h0000;
        send(48, -1, -1, -1, 0);
        send(20, -1, -1, -1, 0);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        send(20, -1, -1, -1, 0);
        check("inject_err1", int'(err_count), 1);
        check("inject_locked", int'(locked), 1);
`endif

        step(1, 1, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
